// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   OP_LOAD / OP_STORE : major opcodes recognised in the M stage
//   F3_*               : funct3 size/extension encodings
//   lsu_state_e        : request/response FSM state
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment helper for the LSU.
//   is_load/is_store : kind of access currently in M
//   funct3, addr_lo  : size encoding and byte offset of that access
//   st_data          : raw rs2 value
//   st_bmask/wdata   : byte enables and lane-replicated store data
//   ld_funct3/lane   : size encoding and byte offset captured at load grant
//   ld_rdata/ld_data : full response word in, aligned/extended value out
//   err              : misaligned access or illegal funct3
module lsu_align (
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_bmask,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data,
  output logic        err
);
  import lsu_pkg::*;

  // Pick the addressed byte/halfword out of an already lane-shifted word
  // and extend it according to funct3.
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[7:0];
    h = w[15:0];
    case (f3)
      F3_B:    load_extend = 32'(b);
      F3_H:    load_extend = 32'(h);
      F3_BU:   load_extend = {24'd0, w[7:0]};
      F3_HU:   load_extend = {16'd0, w[15:0]};
      default: load_extend = w;
    endcase
  endfunction

  logic [31:0] ld_shifted;
  logic        misalign;
  logic        ld_illegal;
  logic        st_illegal;

  always_comb begin
    st_bmask = 4'hF;
    st_wdata = st_data;
    case (funct3)
      F3_B: begin
        st_bmask = 4'b0001 << addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        st_bmask = 4'b0011 << addr_lo;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_shifted = ld_rdata >> {ld_lane, 3'b000};
  assign ld_data    = load_extend(ld_funct3, ld_shifted);

  // funct3[1:0] gives the access size for both signed and unsigned loads.
  assign misalign   = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  assign ld_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
  assign st_illegal = (funct3 > F3_W);
  assign err        = is_load  ? (ld_illegal || misalign) :
                      is_store ? (st_illegal || misalign) : 1'b0;

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit with the MEM/WB pipeline register.
//   i_*_m         : EX/MEM register outputs for the instruction in M
//   o_stall_m     : freezes EX/MEM and upstream while an access is pending
//   o_dmem_* / i_dmem_* : single-outstanding request/response memory port
//   o_*_w         : MEM/WB register (bubble while stalled)
//   o_lsu_err_w   : misaligned or illegal-funct3 access reached WB
module mem_stage_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_alu_data_m,
  input  logic [31:0]       i_rs2_data_m,
  input  logic [31:0]       i_instr_m,
  input  logic [31:0]       i_pc_m,
  input  logic              i_mem_wren_m,
  input  logic              i_rd_wren_m,
  input  logic              i_wb_sel_m,
  output logic              o_stall_m,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [3:0]        o_dmem_bmask,
  input  logic              i_dmem_gnt,
  input  logic              i_dmem_rvalid,
  input  logic [31:0]       i_dmem_rdata,
  output logic [31:0]       o_instr_w,
  output logic [31:0]       o_pc_w,
  output logic [31:0]       o_alu_data_w,
  output logic [31:0]       o_ld_data_w,
  output logic              o_rd_wren_w,
  output logic              o_wb_sel_w,
  output logic              o_lsu_err_w
);
  import lsu_pkg::*;

  lsu_state_e  state_q;
  logic [1:0]  ld_lane_q;
  logic [2:0]  ld_f3_q;

  logic [2:0]  funct3_m;
  logic        is_load_m;
  logic        is_store_m;
  logic        op_err_m;
  logic        issue_m;
  logic        ld_done_m;
  logic [3:0]  st_bmask_m;
  logic [31:0] st_wdata_m;
  logic [31:0] ld_ext_m;

  assign funct3_m   = i_instr_m[14:12];
  assign is_store_m = i_mem_wren_m;
  // A store flag wins so the two access kinds are mutually exclusive.
  assign is_load_m  = (i_instr_m[6:0] == OP_LOAD) && i_wb_sel_m && !i_mem_wren_m;

  lsu_align u_align (
    .is_load   (is_load_m),
    .is_store  (is_store_m),
    .funct3    (funct3_m),
    .addr_lo   (i_alu_data_m[1:0]),
    .st_data   (i_rs2_data_m),
    .st_bmask  (st_bmask_m),
    .st_wdata  (st_wdata_m),
    .ld_funct3 (ld_f3_q),
    .ld_lane   (ld_lane_q),
    .ld_rdata  (i_dmem_rdata),
    .ld_data   (ld_ext_m),
    .err       (op_err_m)
  );

  // Faulting accesses never reach memory; they retire straight to WB.
  // Gating with i_rst keeps the port quiet while reset is held.
  assign issue_m   = i_rst && (state_q == IDLE) && (is_load_m || is_store_m) && !op_err_m;
  assign ld_done_m = (state_q == WAIT_RSP) && i_dmem_rvalid;

  always_comb begin
    o_stall_m = 1'b0;
    if (i_rst) begin
      if (state_q == WAIT_RSP) o_stall_m = !i_dmem_rvalid;
      else                     o_stall_m = issue_m && !(is_store_m && i_dmem_gnt);
    end
  end

  assign o_dmem_req   = issue_m;
  assign o_dmem_we    = issue_m && is_store_m;
  assign o_dmem_addr  = {i_alu_data_m[ADDR_W-1:2], 2'b00};
  assign o_dmem_wdata = st_wdata_m;
  assign o_dmem_bmask = !issue_m ? 4'h0 : (is_store_m ? st_bmask_m : 4'hF);

  // Request FSM; lane and size are latched at grant for the response.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      ld_lane_q <= 2'b00;
      ld_f3_q   <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_m && is_load_m && i_dmem_gnt) begin
            state_q   <= WAIT_RSP;
            ld_lane_q <= i_alu_data_m[1:0];
            ld_f3_q   <= funct3_m;
          end
        end
        WAIT_RSP: begin
          if (i_dmem_rvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---- MEM/WB stage boundary ----
  always_ff @(posedge i_clk) begin
    if (!i_rst || o_stall_m) begin
      o_instr_w    <= 32'd0;
      o_pc_w       <= 32'd0;
      o_alu_data_w <= 32'd0;
      o_ld_data_w  <= 32'd0;
      o_rd_wren_w  <= 1'b0;
      o_wb_sel_w   <= 1'b0;
      o_lsu_err_w  <= 1'b0;
    end else begin
      o_instr_w    <= i_instr_m;
      o_pc_w       <= i_pc_m;
      o_alu_data_w <= i_alu_data_m;
      o_ld_data_w  <= ld_done_m ? ld_ext_m : 32'd0;
      o_rd_wren_w  <= i_rd_wren_m && !op_err_m;
      o_wb_sel_w   <= i_wb_sel_m;
      o_lsu_err_w  <= op_err_m;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, rs2, instr, pc;
  logic        wren, rdwren, wbsel;
  logic        stall, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  bmask;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic [31:0] instr_w, pc_w, alu_w, ld_w;
  logic        rd_wren_w, wb_sel_w, err_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_data_m(alu), .i_rs2_data_m(rs2), .i_instr_m(instr), .i_pc_m(pc),
    .i_mem_wren_m(wren), .i_rd_wren_m(rdwren), .i_wb_sel_m(wbsel),
    .o_stall_m(stall), .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr),
    .o_dmem_wdata(wdata), .o_dmem_bmask(bmask),
    .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
    .o_instr_w(instr_w), .o_pc_w(pc_w), .o_alu_data_w(alu_w), .o_ld_data_w(ld_w),
    .o_rd_wren_w(rd_wren_w), .o_wb_sel_w(wb_sel_w), .o_lsu_err_w(err_w)
  );

  function automatic logic [31:0] ld_ins(input logic [2:0] f3);
    return {17'd0, f3, 5'd5, 7'b0000011};
  endfunction

  function automatic logic [31:0] st_ins(input logic [2:0] f3);
    return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b0100011};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    instr = 32'h00000033; alu = 32'd0; rs2 = 32'd0; pc = 32'd0;
    wren = 1'b0; rdwren = 1'b0; wbsel = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instr = ld_ins(3'd2); alu = 32'h100; wbsel = 1'b1; rdwren = 1'b1; pc = 32'h44;
    gnt = 1'b1; rvalid = 1'b1; rdata = 32'hCAFEF00D;
    cyc(); cyc();
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", req); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
    tests++; if ({instr_w, pc_w, alu_w, ld_w} !== 128'd0) begin fails++; $display("FAIL reset_wb_data: got %h %h %h %h want 0", instr_w, pc_w, alu_w, ld_w); end
    tests++; if ({rd_wren_w, wb_sel_w, err_w} !== 3'b000) begin fails++; $display("FAIL reset_wb_ctl: got %b want 000", {rd_wren_w, wb_sel_w, err_w}); end
    rst = 1'b1; rvalid = 1'b0;
    #1;
    tests++; if (req !== 1'b1) begin fails++; $display("FAIL reset_idle_req: got %b want 1", req); end
    set_idle();
    cyc();
  endtask

  task automatic test_stores();
    instr = st_ins(3'd0); alu = 32'h1003; rs2 = 32'h000000A5; wren = 1'b1; pc = 32'h80; gnt = 1'b1;
    #1;
    tests++; if ({req, we} !== 2'b11) begin fails++; $display("FAIL sb_req_we: got %b want 11", {req, we}); end
    tests++; if (addr !== 32'h1000) begin fails++; $display("FAIL sb_addr: got %h want 00001000", addr); end
    tests++; if (bmask !== 4'b1000) begin fails++; $display("FAIL sb_bmask: got %b want 1000", bmask); end
    tests++; if (wdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL sb_wdata: got %h want a5a5a5a5", wdata); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sb_stall: got %b want 0", stall); end
    cyc();
    tests++; if (instr_w !== st_ins(3'd0) || alu_w !== 32'h1003 || pc_w !== 32'h80) begin fails++; $display("FAIL sb_wb: got %h %h %h", instr_w, alu_w, pc_w); end
    tests++; if (err_w !== 1'b0) begin fails++; $display("FAIL sb_err: got %b want 0", err_w); end
    instr = st_ins(3'd1); alu = 32'h1002; rs2 = 32'h1234ABCD;
    #1;
    tests++; if (bmask !== 4'b1100 || wdata !== 32'hABCDABCD) begin fails++; $display("FAIL sh_lane: got %b %h want 1100 abcdabcd", bmask, wdata); end
    cyc();
    instr = st_ins(3'd2); alu = 32'h0040; rs2 = 32'hDEADBEEF;
    #1;
    tests++; if (bmask !== 4'hF || wdata !== 32'hDEADBEEF || addr !== 32'h40) begin fails++; $display("FAIL sw_lane: got %b %h %h", bmask, wdata, addr); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sw_stall: got %b want 0", stall); end
    set_idle();
    cyc();
  endtask

  task automatic test_load_half();
    instr = ld_ins(3'd1); alu = 32'h2002; wbsel = 1'b1; rdwren = 1'b1; pc = 32'h40; gnt = 1'b1;
    #1;
    tests++; if ({req, we} !== 2'b10 || addr !== 32'h2000) begin fails++; $display("FAIL lh_req: got %b %h want 10 00002000", {req, we}, addr); end
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lh_stall0: got %b want 1", stall); end
    cyc();
    tests++; if (rd_wren_w !== 1'b0 || instr_w !== 32'd0) begin fails++; $display("FAIL lh_bubble: got %b %h want 0 0", rd_wren_w, instr_w); end
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h80010000;
    #1;
    tests++; if ({req, stall} !== 2'b00) begin fails++; $display("FAIL lh_rsp: got %b want 00", {req, stall}); end
    cyc();
    tests++; if (ld_w !== 32'hFFFF8001) begin fails++; $display("FAIL lh_data: got %h want ffff8001", ld_w); end
    tests++; if (rd_wren_w !== 1'b1 || pc_w !== 32'h40) begin fails++; $display("FAIL lh_ctl: got %b %h want 1 00000040", rd_wren_w, pc_w); end
    rvalid = 1'b0; instr = ld_ins(3'd5); gnt = 1'b1;
    #1;
    cyc();
    gnt = 1'b0; rvalid = 1'b1;
    #1;
    cyc();
    tests++; if (ld_w !== 32'h00008001) begin fails++; $display("FAIL lhu_data: got %h want 00008001", ld_w); end
    set_idle();
    cyc();
  endtask

  task automatic test_load_wait();
    int nstall = 0;
    instr = ld_ins(3'd2); alu = 32'h3000; wbsel = 1'b1; rdwren = 1'b1; pc = 32'h90;
    rvalid = 1'b1; rdata = 32'hBAD0BAD0;  // stray rvalid while IDLE
    for (int i = 0; i < 3; i++) begin
      gnt = 1'b0;
      #1;
      if (stall === 1'b1) nstall++;
      tests++; if (req !== 1'b1 || addr !== 32'h3000 || bmask !== 4'hF || we !== 1'b0) begin fails++; $display("FAIL lw_hold%0d: got %b %h %b %b", i, req, addr, bmask, we); end
      cyc();
      tests++; if ({rd_wren_w, instr_w, ld_w} !== 65'd0) begin fails++; $display("FAIL lw_bubble%0d: got %b %h %h", i, rd_wren_w, instr_w, ld_w); end
    end
    gnt = 1'b1; rvalid = 1'b0;
    #1;
    if (stall === 1'b1) nstall++;
    cyc();
    gnt = 1'b0;
    #1;
    if (stall === 1'b1) nstall++;
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL lw_wait_req: got %b want 0", req); end
    cyc();
    tests++; if (rd_wren_w !== 1'b0) begin fails++; $display("FAIL lw_wait_bubble: got %b want 0", rd_wren_w); end
    rvalid = 1'b1; rdata = 32'h12345678;
    #1;
    if (stall === 1'b1) nstall++;
    cyc();
    tests++; if (nstall !== 5) begin fails++; $display("FAIL lw_stall_cycles: got %0d want 5", nstall); end
    tests++; if (ld_w !== 32'h12345678 || rd_wren_w !== 1'b1) begin fails++; $display("FAIL lw_data: got %h %b want 12345678 1", ld_w, rd_wren_w); end
    set_idle();
    cyc();
  endtask

  task automatic test_errors();
    instr = ld_ins(3'd2); alu = 32'h3002; wbsel = 1'b1; rdwren = 1'b1; gnt = 1'b1;
    #1;
    tests++; if ({req, stall} !== 2'b00) begin fails++; $display("FAIL lw_mis_req: got %b want 00", {req, stall}); end
    cyc();
    tests++; if ({err_w, rd_wren_w} !== 2'b10 || ld_w !== 32'd0) begin fails++; $display("FAIL lw_mis_wb: got %b %h want 10 0", {err_w, rd_wren_w}, ld_w); end
    set_idle();
    instr = st_ins(3'd1); alu = 32'h1001; wren = 1'b1; gnt = 1'b1;
    #1;
    tests++; if ({req, stall} !== 2'b00) begin fails++; $display("FAIL sh_mis_req: got %b want 00", {req, stall}); end
    cyc();
    tests++; if (err_w !== 1'b1) begin fails++; $display("FAIL sh_mis_err: got %b want 1", err_w); end
    instr = st_ins(3'd3); alu = 32'h1000;
    #1;
    cyc();
    tests++; if (err_w !== 1'b1) begin fails++; $display("FAIL st_f3_err: got %b want 1", err_w); end
    set_idle();
    cyc();
    tests++; if (err_w !== 1'b0) begin fails++; $display("FAIL err_clear: got %b want 0", err_w); end
  endtask

  task automatic test_passthrough();
    instr = 32'h00A58533; alu = 32'h55; pc = 32'hC0; rdwren = 1'b1;
    #1;
    tests++; if ({req, stall} !== 2'b00) begin fails++; $display("FAIL alu_req: got %b want 00", {req, stall}); end
    cyc();
    tests++; if (alu_w !== 32'h55 || instr_w !== 32'h00A58533 || {rd_wren_w, wb_sel_w} !== 2'b10) begin fails++; $display("FAIL alu_wb: got %h %h %b", alu_w, instr_w, {rd_wren_w, wb_sel_w}); end
    set_idle();
    cyc();
  endtask

  task automatic test_reset_in_wait();
    instr = ld_ins(3'd2); alu = 32'h500; wbsel = 1'b1; rdwren = 1'b1; gnt = 1'b1;
    #1;
    cyc();
    rst = 1'b0; gnt = 1'b0;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rwait_stall: got %b want 0", stall); end
    cyc();
    rst = 1'b1;
    instr = 32'd0; alu = 32'd0; wbsel = 1'b0; rdwren = 1'b0;
    rvalid = 1'b1; rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if ({req, stall} !== 2'b00) begin fails++; $display("FAIL rwait_stray%0d: got %b want 00", i, {req, stall}); end
      cyc();
      tests++; if (ld_w !== 32'd0 || rd_wren_w !== 1'b0) begin fails++; $display("FAIL rwait_wb%0d: got %h %b want 0 0", i, ld_w, rd_wren_w); end
    end
    rvalid = 1'b0;
    instr = ld_ins(3'd0); alu = 32'h501; wbsel = 1'b1; rdwren = 1'b1; gnt = 1'b1;
    #1;
    tests++; if (req !== 1'b1) begin fails++; $display("FAIL rwait_idle: got %b want 1", req); end
    cyc();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h00008000;
    #1;
    cyc();
    tests++; if (ld_w !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_after_reset: got %h want ffffff80", ld_w); end
    set_idle();
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    cyc(); cyc();
    test_reset();
    test_stores();
    test_load_half();
    test_load_wait();
    test_errors();
    test_passthrough();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit for the in-order, non-forwarding pipeline. It consumes the EX/MEM register outputs and drives the data-memory request/response interface. It generates the upstream stall that freezes the EX/MEM and earlier registers while an access is outstanding. It also owns the MEM/WB pipeline register, presenting aligned, extended load data and write-back controls to the WB stage.

## Interface
Parameters:
- ADDR_W, 32, data-memory byte-address width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-low reset
- i_alu_data_m  in  32  effective address (loads/stores) or ALU result
- i_rs2_data_m  in  32  store data
- i_instr_m  in  32  instruction in M; opcode [6:0], funct3 [14:12]
- i_pc_m  in  32  PC of instruction in M
- i_mem_wren_m  in  1  store
- i_rd_wren_m  in  1  register write enable
- i_wb_sel_m  in  1  1 = write back load data, 0 = ALU data
- o_stall_m  out  1  hold EX/MEM and upstream registers
- o_dmem_req  out  1  request valid
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  ADDR_W  word-aligned address, [1:0] = 0
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_bmask  out  4  byte enables
- i_dmem_gnt  in  1  request accepted this cycle
- i_dmem_rvalid  in  1  read data valid
- i_dmem_rdata  in  32  read data (full word)
- o_instr_w, o_pc_w, o_alu_data_w  out  32 each  registered copies
- o_ld_data_w  out  32  extended load data
- o_rd_wren_w, o_wb_sel_w  out  1 each  registered controls
- o_lsu_err_w  out  1  misaligned or illegal funct3 access

## Operation
- Load: opcode 7'b0000011 and i_wb_sel_m=1. Store: i_mem_wren_m=1. Otherwise pass-through.
- FSM states: IDLE, WAIT_RSP.
- IDLE, memory op present: o_dmem_req=1 (combinational). If i_dmem_gnt is low, stay in IDLE and keep the request stable.
- IDLE, store granted: the store completes this cycle.
- IDLE, load granted: go to WAIT_RSP.
- WAIT_RSP: o_dmem_req=0. The load completes on i_dmem_rvalid and the FSM returns to IDLE.
- o_stall_m = memory op present & not completing this cycle.
- Byte enables and store data:
  - SB: bmask 1<<a[1:0], wdata {4{b}}.
  - SH: bmask 3<<a[1:0], wdata {2{h}}.
  - SW: bmask 4'hF.
- Load extract: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged. The lane is selected by the registered address low bits.
- Error cases: halfword with a[0]=1, word with a[1:0]≠0, or funct3 ∈ {3,6,7} (loads) / {3..7} (stores).
  - No request is issued and the op completes immediately.
  - o_lsu_err_w=1, o_rd_wren_w=0, o_ld_data_w=0.
- MEM/WB register:
  - Captures on every edge where o_stall_m=0.
  - While stalled, it loads a bubble: all outputs 0, including o_rd_wren_w.
  - Non-memory instructions pass in one cycle with no stall.
- i_dmem_rvalid in IDLE is ignored.

## Timing
- Reset (i_rst=0 at posedge): FSM=IDLE and all registered outputs are 0. With no op present, o_stall_m=0 and o_dmem_req=0.
- Store, gnt same cycle: 0 stall cycles, MEM/WB valid next cycle.
- Load, gnt same cycle, rvalid next cycle: 1 stall cycle, MEM/WB valid 2 cycles after entry.
- Each cycle of gnt=0 adds one stall cycle. Each cycle of rvalid latency beyond 1 adds one stall cycle.
- gnt and rvalid in the same cycle are never interpreted together. rvalid counts only in WAIT_RSP.
- Reset during WAIT_RSP abandons the load. A subsequent stray rvalid is ignored.
- At most one outstanding request.

## Structure
- lsu_pkg:
  - opcode constants OP_LOAD and OP_STORE.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - lsu_state_e enum {IDLE, WAIT_RSP}.
- Sub-module lsu_align (combinational) contains:
  - store bmask/wdata generation;
  - load extract/extend;
  - misalign/illegal detection.
- The top level contains the FSM, the stall logic and the MEM/WB register.

## Test plan
- Reset: assert i_rst=0 with a load present. Required: all outputs 0, o_dmem_req=0, FSM IDLE.
- SB addr 0x1003, rs2=0x000000A5, gnt=1. Required: bmask 4'b1000, wdata 0xA5A5A5A5, addr 0x1000, no stall.
- LH addr 0x2002, rdata 0x8001_0000 one cycle after gnt. Required: one stall cycle; o_ld_data_w=0xFFFF8001, o_rd_wren_w=1. LHU of the same returns 0x00008001.
- LW with gnt held low 3 cycles, then rvalid 2 cycles after gnt. Required: o_stall_m high for 5 cycles, request fields stable throughout, bubbles in MEM/WB during the stall.
- LW addr 0x3002. Required: no request, o_lsu_err_w=1, o_rd_wren_w=0, no stall.
- Reset asserted in WAIT_RSP, rvalid pulses afterward. Required: FSM stays IDLE and MEM/WB stays 0.
